// File: rtl/el2_ifu_fetch_buf.sv
// Halfword fetch buffer between the IFU memory controller and the aligner.
// Captures F-stage fetch packets as 16-bit parcels and presents a two-parcel window.
module el2_ifu_fetch_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_flush_final,
  input  logic             ic_hit_f,
  input  logic [31:0]      ic_data_f,
  input  logic [1:0]       ic_fetch_val_f,
  input  logic [1:0]       ic_access_fault_f,
  input  logic [1:0]       ic_access_fault_type_f,
  input  logic [30:0]      ifc_fetch_addr_f,
  input  logic [1:0]       fb_consume,
  output logic             fb_ready,
  output logic [1:0]       fb_valid,
  output logic [31:0]      fb_data,
  output logic [30:0]      fb_pc,
  output logic [1:0]       fb_fault,
  output logic [1:0]       fb_fault_type,
  output logic [CNT_W-1:0] fb_count,
  output logic             fb_overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      buf_data  [DEPTH];
  logic [30:0]      buf_pc    [DEPTH];
  logic             buf_fault [DEPTH];
  logic [1:0]       buf_ftype [DEPTH];

  logic [PTR_W-1:0] wptr, rptr, wptr_nx1, rptr_nx1;
  logic [CNT_W-1:0] count, count_next, push_n, pop_n, consume_cl;
  logic             overflow;
  logic             push_en, overflow_set;

  assign fb_ready     = (count <= CNT_W'(DEPTH - 2));
  assign push_en      = ic_hit_f & fb_ready & ~exu_flush_final;
  assign overflow_set = ic_hit_f & (|ic_fetch_val_f) & ~fb_ready & ~exu_flush_final;

  assign wptr_nx1 = wptr + PTR_W'(1);
  assign rptr_nx1 = rptr + PTR_W'(1);

  // A consume request of 3 is illegal and is treated as 2; pops beyond occupancy are clamped.
  assign consume_cl = (fb_consume == 2'd3) ? CNT_W'(2) : CNT_W'(fb_consume);
  assign pop_n      = (consume_cl > count) ? count : consume_cl;
  assign push_n     = push_en ? (CNT_W'(ic_fetch_val_f[0]) + CNT_W'(ic_fetch_val_f[1])) : '0;
  assign count_next = count + push_n - pop_n;

  // Parcel storage: compacted so the first valid halfword always lands at wptr.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (ic_fetch_val_f[0]) begin
        buf_data[wptr]  <= ic_data_f[15:0];
        buf_pc[wptr]    <= ifc_fetch_addr_f;
        buf_fault[wptr] <= ic_access_fault_f[0];
        buf_ftype[wptr] <= ic_access_fault_type_f;
        if (ic_fetch_val_f[1]) begin
          buf_data[wptr_nx1]  <= ic_data_f[31:16];
          buf_pc[wptr_nx1]    <= ifc_fetch_addr_f + 31'd1;
          buf_fault[wptr_nx1] <= ic_access_fault_f[1];
          buf_ftype[wptr_nx1] <= ic_access_fault_type_f;
        end
      end else if (ic_fetch_val_f[1]) begin
        buf_data[wptr]  <= ic_data_f[31:16];
        buf_pc[wptr]    <= ifc_fetch_addr_f + 31'd1;
        buf_fault[wptr] <= ic_access_fault_f[1];
        buf_ftype[wptr] <= ic_access_fault_type_f;
      end
    end
  end

  // Control state: flush discards everything by snapping rptr to wptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (exu_flush_final) begin
        count <= '0;
        rptr  <= wptr;
      end else begin
        count <= count_next;
        rptr  <= rptr + PTR_W'(pop_n);
        wptr  <= wptr + PTR_W'(push_n);
      end
      if (overflow_set) overflow <= 1'b1;
    end
  end

  // Output window from registered state only; invalid parcels read as zero.
  always_comb begin
    fb_valid      = {(count >= CNT_W'(2)), (count != '0)};
    fb_data       = '0;
    fb_pc         = '0;
    fb_fault      = '0;
    fb_fault_type = '0;
    if (fb_valid[0]) begin
      fb_data[15:0] = buf_data[rptr];
      fb_pc         = buf_pc[rptr];
      fb_fault[0]   = buf_fault[rptr];
      fb_fault_type = buf_ftype[rptr];
    end
    if (fb_valid[1]) begin
      fb_data[31:16] = buf_data[rptr_nx1];
      fb_fault[1]    = buf_fault[rptr_nx1];
    end
  end

  assign fb_count    = count;
  assign fb_overflow = overflow;

endmodule

// File: tb/tb_el2_ifu_fetch_buf.sv
// Randomized bench for el2_ifu_fetch_buf against a queue-based parcel model,
// plus directed sequences with literal expectations.
module tb_el2_ifu_fetch_buf;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             exu_flush_final;
  logic             ic_hit_f;
  logic [31:0]      ic_data_f;
  logic [1:0]       ic_fetch_val_f;
  logic [1:0]       ic_access_fault_f;
  logic [1:0]       ic_access_fault_type_f;
  logic [30:0]      ifc_fetch_addr_f;
  logic [1:0]       fb_consume;
  logic             fb_ready;
  logic [1:0]       fb_valid;
  logic [31:0]      fb_data;
  logic [30:0]      fb_pc;
  logic [1:0]       fb_fault;
  logic [1:0]       fb_fault_type;
  logic [CNT_W-1:0] fb_count;
  logic             fb_overflow;

  el2_ifu_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .exu_flush_final(exu_flush_final), .ic_hit_f(ic_hit_f),
    .ic_data_f(ic_data_f), .ic_fetch_val_f(ic_fetch_val_f), .ic_access_fault_f(ic_access_fault_f),
    .ic_access_fault_type_f(ic_access_fault_type_f), .ifc_fetch_addr_f(ifc_fetch_addr_f),
    .fb_consume(fb_consume), .fb_ready(fb_ready), .fb_valid(fb_valid), .fb_data(fb_data),
    .fb_pc(fb_pc), .fb_fault(fb_fault), .fb_fault_type(fb_fault_type), .fb_count(fb_count),
    .fb_overflow(fb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [30:0] pc;
    logic        f;
    logic [1:0]  t;
  } parcel_t;

  parcel_t q[$];
  bit      m_ovf = 0;
  int      errors = 0;
  int      checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO of parcels; flush empties, pops happen before pushes, overflow is sticky.
  task automatic model_step();
    int  sz  = q.size();
    bit  rdy = (DEPTH - sz) >= 2;
    int  c;
    if (exu_flush_final) begin
      q.delete();
    end else begin
      c = (fb_consume == 2'd3) ? 2 : int'(fb_consume);
      if (c > sz) c = sz;
      repeat (c) void'(q.pop_front());
      if (ic_hit_f && rdy) begin
        if (ic_fetch_val_f[0])
          q.push_back({ic_data_f[15:0], ifc_fetch_addr_f, ic_access_fault_f[0], ic_access_fault_type_f});
        if (ic_fetch_val_f[1])
          q.push_back({ic_data_f[31:16], 31'(ifc_fetch_addr_f + 31'd1), ic_access_fault_f[1], ic_access_fault_type_f});
      end
      if (ic_hit_f && (|ic_fetch_val_f) && !rdy) m_ovf = 1;
    end
  endtask

  always @(negedge clk) begin
    parcel_t p0, p1;
    p0 = (q.size() >= 1) ? q[0] : '0;
    p1 = (q.size() >= 2) ? q[1] : '0;
    chk("valid", fb_valid, {q.size() >= 2, q.size() >= 1});
    chk("data", fb_data, {p1.d, p0.d});
    chk("pc", fb_pc, p0.pc);
    chk("fault", fb_fault, {p1.f, p0.f});
    chk("ftype", fb_fault_type, p0.t);
    chk("count", fb_count, q.size());
    chk("ready", fb_ready, (DEPTH - q.size()) >= 2);
    chk("overflow", fb_overflow, m_ovf);
  end

  task automatic cyc(input bit hit, input logic [1:0] val, input logic [31:0] data,
                     input logic [30:0] addr, input logic [1:0] flt, input logic [1:0] ft,
                     input bit fl, input logic [1:0] cons);
    ic_hit_f = hit; ic_fetch_val_f = val; ic_data_f = data; ifc_fetch_addr_f = addr;
    ic_access_fault_f = flt; ic_access_fault_type_f = ft; exu_flush_final = fl; fb_consume = cons;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] pdata(input logic [30:0] a);
    return {16'(a + 31'd1), 16'(a)};
  endfunction

  task automatic push(input logic [1:0] val, input logic [30:0] a, input logic [1:0] cons);
    cyc(1, val, pdata(a), a, 2'b00, 2'b00, 0, cons);
  endtask

  task automatic idle(input logic [1:0] cons);
    cyc(0, 2'b00, 32'h0, 31'h0, 2'b00, 2'b00, 0, cons);
  endtask

  logic [30:0] exp_pc [4];

  initial begin
    rst = 1; exu_flush_final = 0; ic_hit_f = 0; ic_data_f = 0; ic_fetch_val_f = 0;
    ic_access_fault_f = 0; ic_access_fault_type_f = 0; ifc_fetch_addr_f = 0; fb_consume = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", fb_valid, 2'b00);
    chk("rst_data", fb_data, 32'h0);
    chk("rst_count", fb_count, 0);
    chk("rst_ready", fb_ready, 1'b1);
    chk("rst_ovf", fb_overflow, 1'b0);
    rst = 0;

    // Two-parcel push
    cyc(1, 2'b11, 32'hBBBB_AAAA, 31'h100, 2'b00, 2'b00, 0, 2'd0);
    chk("t1_valid", fb_valid, 2'b11);
    chk("t1_data", fb_data, 32'hBBBB_AAAA);
    chk("t1_pc", fb_pc, 31'h100);
    chk("t1_count", fb_count, 2);
    idle(2'd2);
    chk("t1_drain", fb_count, 0);

    // Upper-halfword-only push
    cyc(1, 2'b10, 32'h1234_5678, 31'h200, 2'b00, 2'b00, 0, 2'd0);
    chk("t2_valid", fb_valid, 2'b01);
    chk("t2_data", fb_data, 32'h0000_1234);
    chk("t2_pc", fb_pc, 31'h201);
    chk("t2_count", fb_count, 1);
    idle(2'd2);
    chk("t2_count0", fb_count, 0);
    chk("t2_valid0", fb_valid, 2'b00);

    // Fill, overflow, recover
    for (int i = 0; i < 4; i++) push(2'b11, 31'h500 + 31'(2 * i), 2'd0);
    chk("t3_ready", fb_ready, 1'b0);
    chk("t3_count", fb_count, 8);
    push(2'b11, 31'h600, 2'd0);
    chk("t3_ovf", fb_overflow, 1'b1);
    chk("t3_count8", fb_count, 8);
    chk("t3_pc", fb_pc, 31'h500);
    idle(2'd2);
    chk("t3_ready1", fb_ready, 1'b1);
    chk("t3_count6", fb_count, 6);
    repeat (3) idle(2'd3);
    chk("t3_empty", fb_count, 0);

    // Steady state and read-pointer wrap
    push(2'b11, 31'h300, 2'd0);
    push(2'b01, 31'h310, 2'd0);
    chk("t4_count3", fb_count, 3);
    push(2'b11, 31'h320, 2'd1);
    chk("t4_count4", fb_count, 4);
    chk("t4_pc", fb_pc, 31'h301);
    push(2'b11, 31'h330, 2'd1);
    chk("t4_count5", fb_count, 5);
    chk("t4_pc2", fb_pc, 31'h310);
    exp_pc[0] = 31'h320; exp_pc[1] = 31'h321; exp_pc[2] = 31'h330; exp_pc[3] = 31'h331;
    for (int i = 0; i < 4; i++) begin
      idle(2'd1);
      chk("t4_wrap_pc", fb_pc, exp_pc[i]);
      chk("t4_wrap_d", fb_data[15:0], exp_pc[i][15:0]);
    end
    idle(2'd1);
    chk("t4_empty", fb_count, 0);

    // Flush with simultaneous push
    push(2'b11, 31'h700, 2'd0);
    push(2'b11, 31'h710, 2'd0);
    push(2'b01, 31'h720, 2'd0);
    chk("t5_count5", fb_count, 5);
    cyc(1, 2'b11, pdata(31'h730), 31'h730, 2'b00, 2'b00, 1, 2'd2);
    chk("t5_count0", fb_count, 0);
    chk("t5_valid", fb_valid, 2'b00);
    chk("t5_ready", fb_ready, 1'b1);
    chk("t5_ovf_kept", fb_overflow, 1'b1);
    push(2'b01, 31'h740, 2'd0);
    chk("t5_newpc", fb_pc, 31'h740);
    chk("t5_count1", fb_count, 1);
    idle(2'd1);

    // Fault packet
    cyc(1, 2'b11, 32'hCAFE_F00D, 31'h400, 2'b10, 2'b01, 0, 2'd0);
    chk("t6_fault", fb_fault, 2'b10);
    chk("t6_ftype", fb_fault_type, 2'b01);
    idle(2'd1);
    chk("t6_fault1", fb_fault, 2'b01);
    chk("t6_ftype1", fb_fault_type, 2'b01);
    chk("t6_data", fb_data, 32'h0000_CAFE);
    idle(2'd1);

    // Asynchronous reset mid-operation
    push(2'b11, 31'h800, 2'd0);
    push(2'b11, 31'h802, 2'd0);
    idle(2'd0);
    #2;
    rst = 1;
    q.delete();
    m_ovf = 0;
    #1;
    chk("arst_count", fb_count, 0);
    chk("arst_valid", fb_valid, 2'b00);
    chk("arst_ovf", fb_overflow, 1'b0);
    chk("arst_ready", fb_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 0;

    // Randomized traffic, alternating drain-heavy and fill-heavy phases
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] cons;
      if (((n / 400) % 2) == 0) cons = 2'($urandom_range(0, 3));
      else cons = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc(($urandom % 10) < 7, 2'($urandom), $urandom, 31'($urandom), 2'($urandom), 2'($urandom),
          ($urandom % 60) == 0, cons);
    end
    idle(2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
